// File: rtl/bus_select_decoder_pkg.sv
// Shared constants and FSM state type for the bus-select decoder.
package bus_select_decoder_pkg;

    localparam int unsigned BUS_SEL_W   = 5;
    localparam int unsigned BUS_SRC_N   = 32;
    localparam int unsigned NULL_CODE   = 31;
    localparam int unsigned RESERVED_LO = 24;
    localparam int unsigned RESERVED_HI = 30;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_TURN
    } state_t;

    function automatic logic is_reserved(input logic [BUS_SEL_W-1:0] code);
        return (code >= BUS_SEL_W'(RESERVED_LO)) && (code <= BUS_SEL_W'(RESERVED_HI));
    endfunction

endpackage

// File: rtl/bus_select_decoder_onehot_dec5.sv
// Combinational 5-to-32 one-hot decode; the null code decodes to all zeros.
module onehot_dec5 #(
    parameter logic [bus_select_decoder_pkg::BUS_SEL_W-1:0] NULL_SEL = 5'd31
) (
    input  logic [bus_select_decoder_pkg::BUS_SEL_W-1:0] code,
    output logic [bus_select_decoder_pkg::BUS_SRC_N-1:0] onehot
);
    import bus_select_decoder_pkg::*;

    always_comb begin
        onehot = '0;
        for (int unsigned i = 0; i < BUS_SRC_N; i++) begin
            onehot[i] = (code == BUS_SEL_W'(i)) && (code != NULL_SEL);
        end
    end

endmodule

// File: rtl/bus_select_decoder.sv
// Bus grant sequencer: code -> registered one-hot drive enable with hold and turnaround.
// Optional macro BUS_DEC_RESERVED_CHECK_EN rejects codes 24..30 with a code_err pulse.
module bus_select_decoder #(
    parameter int unsigned HOLD_CYCLES = 1,
    parameter int unsigned TURNAROUND  = 1,
    parameter int unsigned NULL_CODE   = bus_select_decoder_pkg::NULL_CODE
) (
    input  logic                                          clock,
    input  logic                                          clear,
    input  logic                                          req_valid,
    input  logic [bus_select_decoder_pkg::BUS_SEL_W-1:0]  req_code,
    output logic                                          req_ready,
    output logic [bus_select_decoder_pkg::BUS_SRC_N-1:0]  drive_en,
    output logic                                          busy,
    output logic                                          code_err
);
    import bus_select_decoder_pkg::*;

    localparam int unsigned CNT_MAX = (HOLD_CYCLES > TURNAROUND) ? HOLD_CYCLES : TURNAROUND;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURNAROUND - 1);
    localparam logic [BUS_SEL_W-1:0] NULL_SEL = BUS_SEL_W'(NULL_CODE);

    state_t                 state, state_n;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic [BUS_SEL_W-1:0]   cur_code, cur_n;
    logic [BUS_SRC_N-1:0]   drive_n;
    logic [BUS_SRC_N-1:0]   dec_onehot;
    logic                   reserved;

    onehot_dec5 #(.NULL_SEL(NULL_SEL)) u_dec (
        .code   (req_code),
        .onehot (dec_onehot)
    );

`ifdef BUS_DEC_RESERVED_CHECK_EN
    logic err_q, err_n;
    assign reserved = is_reserved(req_code);
    assign code_err = err_q;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) err_q <= 1'b0;
        else       err_q <= err_n;
    end
`else
    assign reserved = 1'b0;
    assign code_err = 1'b0;
`endif

    assign busy = (state != ST_IDLE);

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        cur_n     = cur_code;
        drive_n   = drive_en;
        req_ready = 1'b0;
`ifdef BUS_DEC_RESERVED_CHECK_EN
        err_n     = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                drive_n   = '0;
                if (req_valid && (req_code != NULL_SEL)) begin
                    if (reserved) begin
`ifdef BUS_DEC_RESERVED_CHECK_EN
                        err_n = 1'b1;
`endif
                    end else begin
                        cur_n   = req_code;
                        drive_n = dec_onehot;
                        cnt_n   = HOLD_LOAD;
                        state_n = ST_DRIVE;
                    end
                end
            end
            ST_DRIVE: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    // A reserved code can never equal cur_code, so it always falls to TURN.
                    req_ready = (req_code == cur_code);
                    if (req_valid && req_ready) begin
                        cnt_n = HOLD_LOAD;
                    end else begin
                        drive_n = '0;
                        cnt_n   = TURN_LOAD;
                        state_n = ST_TURN;
                    end
                end
            end
            ST_TURN: begin
                drive_n = '0;
                if (cnt != '0) cnt_n = cnt - 1'b1;
                else           state_n = ST_IDLE;
            end
            default: begin
                drive_n = '0;
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            cur_code <= NULL_SEL;
            drive_en <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            cur_code <= cur_n;
            drive_en <= drive_n;
        end
    end

endmodule

// File: tb/tb_bus_select_decoder.sv
// Scoreboard bench: two parameterisations share stimulus; a timestamp model predicts each cycle.
module tb_bus_select_decoder;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        req_valid = 1'b0;
    logic [4:0]  req_code = 5'd0;
    logic        rdy0, rdy1, busy0, busy1, err0, err1;
    logic [31:0] drv0, drv1;

    bus_select_decoder #(.HOLD_CYCLES(1), .TURNAROUND(1), .NULL_CODE(31)) dut0 (
        .clock(clock), .clear(clear), .req_valid(req_valid), .req_code(req_code),
        .req_ready(rdy0), .drive_en(drv0), .busy(busy0), .code_err(err0)
    );

    bus_select_decoder #(.HOLD_CYCLES(2), .TURNAROUND(3), .NULL_CODE(31)) dut1 (
        .clock(clock), .clear(clear), .req_valid(req_valid), .req_code(req_code),
        .req_ready(rdy1), .drive_en(drv1), .busy(busy1), .code_err(err1)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] drive;
        logic        busy;
        logic        ready;
        logic        chk_ready;
        logic        err;
        int          t;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int tests = 0;
    int fails = 0;
    int t = 0;
    int hold_c[2] = '{1, 2};
    int turn_c[2] = '{1, 3};
    // Model state as timestamps: drive cycles lo..hi, idle again from free_at.
    int lo[2], hi[2], free_at[2], cur[2], err_at[2];

    function automatic bit is_rsv(int c);
`ifdef BUS_DEC_RESERVED_CHECK_EN
        return (c >= 24) && (c <= 30);
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(string name, int k, int tc, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d t=%0d got %h expected %h", name, k, tc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            lo[k] = 0; hi[k] = -1; free_at[k] = t; err_at[k] = -1; cur[k] = 31;
        end
    endtask

    task automatic model_step(int k, bit v, int c, output exp_t e);
        bit idle;
        e.t       = t;
        e.drive   = (t >= lo[k] && t <= hi[k]) ? (32'd1 << cur[k]) : 32'd0;
        e.busy    = (t < free_at[k]);
        idle      = !e.busy;
        e.ready   = idle ? 1'b1 : (t == hi[k] && c == cur[k]);
        e.chk_ready = idle || v;
        e.err     = (t == err_at[k]);
        if (v && e.ready) begin
            if (idle) begin
                if (c != 31) begin
                    if (is_rsv(c)) begin
                        err_at[k] = t + 1;
                    end else begin
                        cur[k] = c;
                        lo[k] = t + 1;
                        hi[k] = t + hold_c[k];
                        free_at[k] = hi[k] + turn_c[k] + 1;
                    end
                end
            end else begin
                hi[k] = t + hold_c[k];
                free_at[k] = hi[k] + turn_c[k] + 1;
            end
        end
    endtask

    task automatic cycle(bit v, int c);
        exp_t e;
        @(posedge clock);
        #1;
        req_valid = v;
        req_code  = 5'(c);
        model_step(0, v, c, e); q0.push_back(e);
        model_step(1, v, c, e); q1.push_back(e);
        t++;
    endtask

    task automatic check_outs(int k, exp_t e, logic [31:0] drv, logic bsy, logic rdy, logic err);
        chk("drive_en", k, e.t, drv, e.drive);
        chk("busy", k, e.t, 32'(bsy), 32'(e.busy));
        if (e.chk_ready) chk("req_ready", k, e.t, 32'(rdy), 32'(e.ready));
        chk("code_err", k, e.t, 32'(err), 32'(e.err));
        chk("onehot0", k, e.t, 32'($onehot0(drv)), 32'd1);
        if (!bsy) chk("idle_quiet", k, e.t, drv, 32'd0);
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (!clear) begin
            if (q0.size() > 0) begin
                e = q0.pop_front();
                check_outs(0, e, drv0, busy0, rdy0, err0);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check_outs(1, e, drv1, busy1, rdy1, err1);
            end
        end
    end

    initial begin
        int v, r, c, last;
        model_reset();
        #12;
        chk("rst_drive", 0, t, drv0, 32'd0);
        chk("rst_drive", 1, t, drv1, 32'd0);
        chk("rst_busy", 0, t, 32'(busy0), 32'd0);
        chk("rst_busy", 1, t, 32'(busy1), 32'd0);
        chk("rst_err", 0, t, 32'(err0), 32'd0);
        @(posedge clock);
        #1 clear = 1'b0;
        model_reset();

        // Asynchronous clear while both instances drive code 5.
        cycle(1, 5);
        cycle(0, 0);
        @(negedge clock);
        #1 clear = 1'b1;
        #1;
        chk("clr_drive", 0, t, drv0, 32'd0);
        chk("clr_drive", 1, t, drv1, 32'd0);
        chk("clr_busy", 0, t, 32'(busy0), 32'd0);
        chk("clr_busy", 1, t, 32'(busy1), 32'd0);
        @(posedge clock);
        #1 clear = 1'b0;
        model_reset();
        #1;
        chk("clr_ready", 0, t, 32'(rdy0), 32'd1);
        chk("clr_ready", 1, t, 32'(rdy1), 32'd1);

        cycle(1, 3);
        repeat (6) cycle(0, 0);
        repeat (9) cycle(1, 7);
        repeat (6) cycle(0, 0);
        cycle(1, 2);
        repeat (10) cycle(1, 9);
        repeat (7) cycle(0, 0);
        cycle(1, 31);
        cycle(0, 0);
        cycle(1, 27);
        repeat (3) cycle(0, 0);
        cycle(1, 0);
        repeat (6) cycle(0, 0);
        cycle(1, 30);
        repeat (7) cycle(1, 30);
        repeat (6) cycle(0, 0);

        last = 0;
        repeat (500) begin
            v = ($urandom_range(0, 9) < 7) ? 1 : 0;
            r = $urandom_range(0, 9);
            if (r < 4)      c = last;
            else if (r < 5) c = 31;
            else if (r < 6) c = $urandom_range(24, 30);
            else            c = $urandom_range(0, 31);
            last = c;
            cycle(v[0], c);
        end
        cycle(0, 0);
        repeat (2) @(posedge clock);
        if (q0.size() != 0 || q1.size() != 0) begin
            fails++;
            $display("FAIL drain left %0d/%0d entries expected 0", q0.size(), q1.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
